alu_mc_core: RTL
================

// Module: alu_mc_core
// PURPOSE
//  Parametrised multi-cycle successor to the 8-bit combinational ALU: same 3-bit opcode map, WIDTH-generic.
//  Adds registered outputs, valid/ready handshakes on both sides, and an iterative shift-add multiplier.
//  Sits between an operand-issuing controller and a result consumer; one operation in flight at a time.
// PARAMETERS
//  WIDTH   8   operand width in bits (>=2); result width is 2*WIDTH
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        operand/opcode valid
//  in_ready   out  1        core can accept an operation
//  a          in   WIDTH    operand A
//  b          in   WIDTH    operand B
//  sel        in   3        opcode: 000 NOT A, 001 OR, 010 AND, 011 XOR, 100 ADD, 101 SUB, 110 MUL, 111 NOT B
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  y          out  2*WIDTH  result
//  cout       out  1        carry (ADD) / borrow (SUB), else 0
//  flags      out  2        {zero, msb} of y[WIDTH-1:0] for non-MUL, of full y for MUL; present only with ALU_FLAGS_EN
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, y=0, cout=0, flags=0, mul counter=0; in_ready deasserted while rst_n low.
//  - Accept = in_valid & in_ready at a rising edge; a/b/sel captured; ignored otherwise.
//  - in_ready = (state==IDLE) & (!out_valid | out_ready): accept allowed in the same cycle a result drains.
//  - States: IDLE -> (accept, sel!=110) IDLE with result registered; IDLE -> (accept, sel==110) MUL;
//    MUL -> after WIDTH iterations, IDLE with result registered. No other transitions.
//  - Latency: non-MUL out_valid high 1 cycle after accept edge; MUL out_valid high WIDTH cycles after accept edge.
//  - Throughput: non-MUL 1 op/cycle with out_ready held high; MUL blocks input (in_ready=0) for whole MUL state.
//  - out_valid stays high and y/cout/flags stay stable until out_ready sampled high; then out_valid drops unless
//    a new result is registered in the same edge.
//  - Width rules (upper WIDTH bits of y zero unless stated):
//    NOT A/NOT B: y[W-1:0]=~a / ~b, cout=0. OR/AND/XOR: bitwise, cout=0.
//    ADD: {cout,y[W-1:0]} = a+b (W+1 bits). SUB: y[W-1:0]=(a-b) mod 2^W, cout=1 iff a<b (borrow).
//    MUL: y = a*b unsigned, full 2*WIDTH bits, cout=0; shift-add, one partial product per cycle.
//  - Reset asserted mid-MUL: operation abandoned, no result produced, all state to reset values.
//  - out_ready with out_valid=0 has no effect; in_valid while in_ready=0 is not captured (source must hold).
// CONFIGURATION
//  - ALU_FLAGS_EN defined: flags port exists; zero=1 iff examined bits all 0, msb=top examined bit; registered
//    with y, same validity and hold rules.
//  - ALU_FLAGS_EN undefined: no flags port, no flag logic; all other behaviour identical.
// STRUCTURE
//  - Package alu_pkg: opcode localparams (OP_NOTA..OP_NOTB, 3 bits), state encoding (ST_IDLE, ST_MUL).
//  - Sub-module alu_mul_seq: WIDTH-parametrised shift-add multiplier, start/done pulse interface, clk/rst_n;
//    top holds handshake FSM, logic/add/sub datapath and result register.
// TESTING (WIDTH=8)
//  - SUB a=0x04 b=0x0A, out_ready=1 -> next cycle out_valid=1, y=0x00FA, cout=1.
//  - ADD a=0xFF b=0x01 -> y=0x0000, cout=1; XOR a=0x10 b=0x03 -> y=0x0013, cout=0; back-to-back, one per cycle.
//  - MUL a=0x02 b=0x0A -> in_ready=0 for 8 cycles, out_valid after 8 cycles, y=0x0014; MUL 0xFF*0xFF -> y=0xFE01.
//  - Backpressure: OR 0x05|0x06 with out_ready=0 for 3 cycles -> y=0x0007 stable, in_ready=0, single result on release.
//  - Reset low 4 cycles into MUL -> outputs to reset values, no stale result after release; next NOT A 0x01 -> y=0x00FE.
//  - ALU_FLAGS_EN: AND 0x02&0x05 -> y=0, flags=2'b10; NOT B 0x02 -> y=0x00FD, flags=2'b01.

Source files
------------

// File: rtl/alu_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_pkg                                                                  |
// | Opcode map and handshake FSM state encoding shared by the ALU core.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

    localparam logic [2:0] OP_NOTA = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_NOTB = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// +--------------------------------------------------------------------------+
// | alu_mul_seq                                                              |
// | Iterative unsigned shift-add multiplier, one partial product per cycle.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int                  c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0]  c_one   = c_cnt_w'(1);

    logic                   r_busy;
    logic [c_cnt_w-1:0]     r_count;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     w_addend;
    logic [2*WIDTH-1:0]     w_acc_next;

    // done fires on the final iteration; product is that iteration's sum so the
    // caller can register it on the same edge.
    always_comb begin
        w_addend   = r_mplier[0] ? r_mcand : '0;
        w_acc_next = r_acc + w_addend;
        done       = r_busy && (r_count == c_last);
        product    = w_acc_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_count  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_count  <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (done) begin
                r_busy  <= 1'b0;
                r_count <= '0;
            end else begin
                r_count <= r_count + c_one;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_mc_core.sv
// +--------------------------------------------------------------------------+
// | alu_mc_core                                                              |
// | Multi-cycle WIDTH-generic ALU with valid/ready on both sides and a       |
// | sequential multiplier. Define ALU_FLAGS_EN to add the {zero,msb} port.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_mc_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 cout
`ifdef ALU_FLAGS_EN
    ,
    output logic [1:0]           flags
`endif
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_out_valid;
    logic [2*WIDTH-1:0]     r_y;
    logic                   r_cout;

    logic                   w_accept;
    logic                   w_start_mul;
    logic                   w_load_alu;
    logic                   w_mul_done;
    logic [2*WIDTH-1:0]     w_mul_product;
    logic [WIDTH-1:0]       w_lo;
    logic                   w_carry;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_diff;

    // Single-cycle datapath; the MSB of the widened difference is the borrow.
    always_comb begin
        w_sum   = {1'b0, a} + {1'b0, b};
        w_diff  = {1'b0, a} - {1'b0, b};
        w_lo    = '0;
        w_carry = 1'b0;
        case (sel)
            OP_NOTA: w_lo = ~a;
            OP_OR:   w_lo = a | b;
            OP_AND:  w_lo = a & b;
            OP_XOR:  w_lo = a ^ b;
            OP_ADD: begin
                w_lo    = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_lo    = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
            end
            OP_NOTB: w_lo = ~b;
            default: w_lo = '0;
        endcase
    end

    // A result may drain and a new operation be accepted on the same edge.
    always_comb begin
        in_ready     = rst_n && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
        w_accept     = in_valid && in_ready;
        w_start_mul  = w_accept && (sel == OP_MUL);
        w_load_alu   = w_accept && (sel != OP_MUL);
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_mul) w_state_next = ST_MUL;
            ST_MUL:  if (w_mul_done)  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_cout      <= 1'b0;
        end else if (w_load_alu) begin
            r_out_valid <= 1'b1;
            r_y         <= {{WIDTH{1'b0}}, w_lo};
            r_cout      <= w_carry;
        end else if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_y         <= w_mul_product;
            r_cout      <= 1'b0;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    alu_mul_seq #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_start_mul),
        .a       (a),
        .b       (b),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign cout      = r_cout;

`ifdef ALU_FLAGS_EN
    logic [1:0] r_flags;

    // Non-MUL flags look at the low half only; MUL flags cover the full product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 2'b00;
        end else if (w_load_alu) begin
            r_flags <= {~|w_lo, w_lo[WIDTH-1]};
        end else if (w_mul_done) begin
            r_flags <= {~|w_mul_product, w_mul_product[2*WIDTH-1]};
        end
    end

    assign flags = r_flags;
`endif

endmodule

`default_nettype wire
